// File: rtl/window_gen_kxk_if.sv
// Window generator bus: BRAM read port, 3x3 window output to the MAC and frame control.
// master = window generator, slave = BRAM/MAC side.
interface window_gen_kxk_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 17
);
  logic              iStart;
  logic              oCs;
  logic [ADDR_W-1:0] oAddr;
  logic [DATA_W-1:0] iPixel;
  logic [DATA_W-1:0] oOut0, oOut1, oOut2, oOut3, oOut4, oOut5, oOut6, oOut7, oOut8;
  logic              oValid;
  logic              iBusy;
  logic [15:0]       oRow;
  logic [15:0]       oCol;
  logic              oLast;
  logic              oDone;

  modport master (
    input  iStart, iPixel, iBusy,
    output oCs, oAddr, oOut0, oOut1, oOut2, oOut3, oOut4, oOut5, oOut6, oOut7, oOut8,
    output oValid, oRow, oCol, oLast, oDone
  );

  modport slave (
    output iStart, iPixel, iBusy,
    input  oCs, oAddr, oOut0, oOut1, oOut2, oOut3, oOut4, oOut5, oOut6, oOut7, oOut8,
    input  oValid, oRow, oCol, oLast, oDone
  );
endinterface

// File: rtl/window_gen_kxk.sv
// 3x3 window generator over a BRAM frame (optional zero pad, stride 1/2); first window 11 cycles after start.
// iBusy stalls in EMIT with window/coords held and no reads; out-of-frame slots drop oCs and insert zero.
module window_gen_kxk #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 17,
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 272,
  parameter int PAD    = 1,
  parameter int STRIDE = 1
) (
  input logic             iClk,
  input logic             iRst,
  window_gen_kxk_if.master bus
);
  localparam int OW = (PAD != 0) ? (WIDTH - 1) / STRIDE + 1 : (WIDTH - 3) / STRIDE + 1;
  localparam int OH = (PAD != 0) ? (HEIGHT - 1) / STRIDE + 1 : (HEIGHT - 3) / STRIDE + 1;
  localparam logic [15:0] OW_M1   = 16'(OW - 1);
  localparam logic [15:0] OH_M1   = 16'(OH - 1);
  localparam logic [1:0]  STEP_M1 = 2'(STRIDE - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_EMIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       r_q, r_d, c_q, c_d;
  logic [1:0]        frow_q, frow_d, fcol_q, fcol_d;
  logic              row_start_q, row_start_d;
  logic              cs_q, cs_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic              cap_vld_q, cap_vld_d, cap_oob_q, cap_oob_d;
  logic [1:0]        cap_row_q, cap_row_d;
  logic [DATA_W-1:0] nc0_q, nc0_d, nc1_q, nc1_d;
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];
  logic [DATA_W-1:0] pix;
  logic              xfer;
  int                ir, ic;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    frow_d      = frow_q;
    fcol_d      = fcol_q;
    row_start_d = row_start_q;
    nc0_d       = nc0_q;
    nc1_d       = nc1_q;
    win_d       = win_q;
    cs_d        = 1'b0;
    addr_d      = '0;
    ir          = 0;
    ic          = 0;
    xfer        = valid_q & ~bus.iBusy;
    pix         = cap_oob_q ? '0 : bus.iPixel;
    // Each issued slot is tagged so its datum lands in the right row next cycle.
    cap_vld_d   = (state_q == S_FETCH);
    cap_oob_d   = ~cs_q;
    cap_row_d   = frow_q;

    case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          state_d     = S_FETCH;
          r_d         = '0;
          c_d         = '0;
          row_start_d = 1'b1;
          frow_d      = '0;
          fcol_d      = '0;
        end
      end
      S_FETCH: begin
        if (frow_q == 2'd2) begin
          frow_d = '0;
          if (fcol_q == (row_start_q ? 2'd2 : STEP_M1)) state_d = S_DRAIN;
          else fcol_d = fcol_q + 2'd1;
        end else begin
          frow_d = frow_q + 2'd1;
        end
      end
      S_DRAIN: state_d = S_EMIT;
      S_EMIT: begin
        if (xfer) begin
          frow_d = '0;
          fcol_d = '0;
          if (c_q < OW_M1) begin
            c_d         = c_q + 16'd1;
            row_start_d = 1'b0;
            state_d     = S_FETCH;
          end else if (r_q < OH_M1) begin
            r_d         = r_q + 16'd1;
            c_d         = '0;
            row_start_d = 1'b1;
            state_d     = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Address of the slot presented next cycle; a row start refetches all three columns.
    if (state_d == S_FETCH) begin
      ir = int'(r_d) * STRIDE - PAD + int'(frow_d);
      ic = int'(c_d) * STRIDE - PAD + (row_start_d ? 0 : 3 - STRIDE) + int'(fcol_d);
      if (ir >= 0 && ir < HEIGHT && ic >= 0 && ic < WIDTH) begin
        cs_d   = 1'b1;
        addr_d = ADDR_W'(ir * WIDTH + ic);
      end
    end

    valid_d = (state_d == S_EMIT);
    last_d  = valid_d && (r_d == OH_M1) && (c_d == OW_M1);
    done_d  = (state_d == S_DONE);

    if (cap_vld_q) begin
      case (cap_row_q)
        2'd0:    nc0_d = pix;
        2'd1:    nc1_d = pix;
        default: begin
          for (int k = 0; k < 3; k++) begin
            win_d[3*k]   = win_q[3*k+1];
            win_d[3*k+1] = win_q[3*k+2];
          end
          win_d[2] = nc0_q;
          win_d[5] = nc1_q;
          win_d[8] = pix;
        end
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      c_q         <= '0;
      frow_q      <= '0;
      fcol_q      <= '0;
      row_start_q <= 1'b0;
      cs_q        <= 1'b0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_oob_q   <= 1'b0;
      cap_row_q   <= '0;
      nc0_q       <= '0;
      nc1_q       <= '0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      frow_q      <= frow_d;
      fcol_q      <= fcol_d;
      row_start_q <= row_start_d;
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
      cap_vld_q   <= cap_vld_d;
      cap_oob_q   <= cap_oob_d;
      cap_row_q   <= cap_row_d;
      nc0_q       <= nc0_d;
      nc1_q       <= nc1_d;
      for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
    end
  end

  assign bus.oCs    = cs_q;
  assign bus.oAddr  = addr_q;
  assign bus.oValid = valid_q;
  assign bus.oLast  = last_q;
  assign bus.oDone  = done_q;
  assign bus.oRow   = r_q;
  assign bus.oCol   = c_q;
  assign bus.oOut0  = win_q[0];
  assign bus.oOut1  = win_q[1];
  assign bus.oOut2  = win_q[2];
  assign bus.oOut3  = win_q[3];
  assign bus.oOut4  = win_q[4];
  assign bus.oOut5  = win_q[5];
  assign bus.oOut6  = win_q[6];
  assign bus.oOut7  = win_q[7];
  assign bus.oOut8  = win_q[8];
endmodule

// File: tb/tb_window_gen_kxk.sv
// Directed bench: three instances (valid-only 5x4, padded 5x4, stride-2 5x5), BRAM model pixel = address+1.
module tb_window_gen_kxk;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   csa = 0, csb = 0;
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  window_gen_kxk_if #(.DATA_W(24), .ADDR_W(17)) ifa ();
  window_gen_kxk_if #(.DATA_W(24), .ADDR_W(17)) ifb ();
  window_gen_kxk_if #(.DATA_W(24), .ADDR_W(17)) ifc ();

  window_gen_kxk #(.DATA_W(24), .ADDR_W(17), .WIDTH(5), .HEIGHT(4), .PAD(0), .STRIDE(1))
    dut_a (.iClk(clk), .iRst(rst), .bus(ifa));
  window_gen_kxk #(.DATA_W(24), .ADDR_W(17), .WIDTH(5), .HEIGHT(4), .PAD(1), .STRIDE(1))
    dut_b (.iClk(clk), .iRst(rst), .bus(ifb));
  window_gen_kxk #(.DATA_W(24), .ADDR_W(17), .WIDTH(5), .HEIGHT(5), .PAD(0), .STRIDE(2))
    dut_c (.iClk(clk), .iRst(rst), .bus(ifc));

  // 1-cycle BRAMs; garbage when not enabled so a zero must come from the DUT itself.
  always @(posedge clk) ifa.iPixel <= ifa.oCs ? 24'(ifa.oAddr) + 24'd1 : 24'hDEAD00;
  always @(posedge clk) ifb.iPixel <= ifb.oCs ? 24'(ifb.oAddr) + 24'd1 : 24'hDEAD00;
  always @(posedge clk) ifc.iPixel <= ifc.oCs ? 24'(ifc.oAddr) + 24'd1 : 24'hDEAD00;
  always @(posedge clk) if (ifa.oCs) csa <= csa + 1;
  always @(posedge clk) if (ifb.oCs) csb <= csb + 1;

  function automatic int exp_pix(int w, int h, int pad, int st, int r, int c, int k);
    int pr, pc;
    pr = r * st - pad + k / 3;
    pc = c * st - pad + k % 3;
    if (pr < 0 || pr >= h || pc < 0 || pc >= w) return 0;
    return pr * w + pc + 1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    ifa.iStart = 0; ifb.iStart = 0; ifc.iStart = 0;
    ifa.iBusy = 0;  ifb.iBusy = 0;  ifc.iBusy = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({ifa.oValid, ifa.oCs, ifa.oDone, ifa.oLast} !== 4'b0) begin n_bad++;
      $display("FAIL rst_ctl: got %b want 0000", {ifa.oValid, ifa.oCs, ifa.oDone, ifa.oLast}); end
    n_cmp++; if (ifa.oAddr !== 17'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", ifa.oAddr); end
    n_cmp++; if ({ifa.oRow, ifa.oCol} !== 32'd0) begin n_bad++;
      $display("FAIL rst_coord: got (%0d,%0d) want (0,0)", ifa.oRow, ifa.oCol); end
    n_cmp++; if (ifa.oOut4 !== 24'd0) begin n_bad++; $display("FAIL rst_out4: got %0d want 0", ifa.oOut4); end
    n_cmp++; if ({ifb.oOut0, ifb.oOut8} !== 48'd0) begin n_bad++; $display("FAIL rst_b_win: got %0h want 0", {ifb.oOut0, ifb.oOut8}); end
    n_cmp++; if ({ifc.oValid, ifc.oCs} !== 2'b0) begin n_bad++; $display("FAIL rst_c_ctl: got %b want 00", {ifc.oValid, ifc.oCs}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({ifa.oValid, ifa.oCs} !== 2'b0) begin n_bad++;
      $display("FAIL idle_no_start: got %b want 00", {ifa.oValid, ifa.oCs}); end
  endtask

  task automatic test_valid_only();
    int s, nwin, t, t_prev, er, ec, cs0;
    bit got_done;
    cs0 = csa;
    ifa.iStart = 1; s = cyc; @(negedge clk); ifa.iStart = 0;
    repeat (9) @(negedge clk);
    n_cmp++; if (ifa.oValid !== 1'b0) begin n_bad++; $display("FAIL a_valid_c10: got %b want 0", ifa.oValid); end
    @(negedge clk);
    n_cmp++; if ({ifa.oOut0, ifa.oOut4, ifa.oOut8} !== {24'd1, 24'd7, 24'd13}) begin n_bad++;
      $display("FAIL a_first_win: got %0d/%0d/%0d want 1/7/13", ifa.oOut0, ifa.oOut4, ifa.oOut8); end
    nwin = 0; er = 0; ec = 0; t_prev = 0; got_done = 0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      t = cyc - s;
      if (ifa.oDone) begin
        got_done = 1;
        n_cmp++; if (t !== t_prev + 1 || ifa.oValid !== 1'b0) begin n_bad++;
          $display("FAIL a_done: got cycle %0d valid %b want cycle %0d valid 0", t, ifa.oValid, t_prev + 1); end
      end else if (ifa.oValid) begin
        nwin++;
        n_cmp++; if (t !== ((nwin == 1) ? 11 : t_prev + ((ec == 0) ? 11 : 5))) begin n_bad++;
          $display("FAIL a_timing: window %0d at cycle %0d, previous %0d", nwin, t, t_prev); end
        n_cmp++; if (ifa.oRow !== 16'(er) || ifa.oCol !== 16'(ec)) begin n_bad++;
          $display("FAIL a_coord: got (%0d,%0d) want (%0d,%0d)", ifa.oRow, ifa.oCol, er, ec); end
        n_cmp++; if (ifa.oOut4 !== 24'(exp_pix(5, 4, 0, 1, er, ec, 4)) || ifa.oOut8 !== 24'(exp_pix(5, 4, 0, 1, er, ec, 8))) begin n_bad++;
          $display("FAIL a_win: (%0d,%0d) got %0d/%0d", er, ec, ifa.oOut4, ifa.oOut8); end
        n_cmp++; if (ifa.oLast !== ((er == 1 && ec == 2) ? 1'b1 : 1'b0)) begin n_bad++;
          $display("FAIL a_last: (%0d,%0d) got %b", er, ec, ifa.oLast); end
        t_prev = t;
        if (ec == 2) begin ec = 0; er++; end else ec++;
      end
      if (!got_done) @(negedge clk);
    end
    n_cmp++; if (!got_done || nwin != 6) begin n_bad++; $display("FAIL a_count: got %0d windows done %0d want 6 done 1", nwin, got_done); end
    @(negedge clk);
    n_cmp++; if (ifa.oDone !== 1'b0) begin n_bad++; $display("FAIL a_done_pulse: got %b want 0", ifa.oDone); end
    n_cmp++; if (csa - cs0 != 30) begin n_bad++; $display("FAIL a_reads: got %0d want 30", csa - cs0); end
  endtask

  task automatic test_padding();
    int s, nwin, er, ec, cs0;
    bit got_done;
    logic [23:0] w [9];
    int first_w [9] = '{0, 0, 0, 0, 1, 2, 0, 6, 7};
    int last_w  [9] = '{14, 15, 0, 19, 20, 0, 0, 0, 0};
    cs0 = csb;
    ifb.iStart = 1; s = cyc; @(negedge clk); ifb.iStart = 0;
    nwin = 0; er = 0; ec = 0; got_done = 0;
    for (int i = 0; i < 600 && !got_done; i++) begin
      w = '{ifb.oOut0, ifb.oOut1, ifb.oOut2, ifb.oOut3, ifb.oOut4, ifb.oOut5, ifb.oOut6, ifb.oOut7, ifb.oOut8};
      if (ifb.oDone) got_done = 1;
      else if (ifb.oValid) begin
        nwin++;
        if (nwin == 1) begin
          n_cmp++; if (cyc - s != 11) begin n_bad++; $display("FAIL b_first_cycle: got %0d want 11", cyc - s); end
          for (int k = 0; k < 9; k++) begin
            n_cmp++; if (w[k] !== 24'(first_w[k])) begin n_bad++; $display("FAIL b_first_win[%0d]: got %0d want %0d", k, w[k], first_w[k]); end
          end
        end
        if (er == 3 && ec == 4) begin
          for (int k = 0; k < 9; k++) begin
            n_cmp++; if (w[k] !== 24'(last_w[k])) begin n_bad++; $display("FAIL b_win34[%0d]: got %0d want %0d", k, w[k], last_w[k]); end
          end
        end
        for (int k = 0; k < 9; k++) begin
          n_cmp++; if (w[k] !== 24'(exp_pix(5, 4, 1, 1, er, ec, k))) begin n_bad++;
            $display("FAIL b_win: (%0d,%0d)[%0d] got %0d want %0d", er, ec, k, w[k], exp_pix(5, 4, 1, 1, er, ec, k)); end
        end
        n_cmp++; if (ifb.oRow !== 16'(er) || ifb.oCol !== 16'(ec) || ifb.oLast !== ((er == 3 && ec == 4) ? 1'b1 : 1'b0)) begin n_bad++;
          $display("FAIL b_coord: got (%0d,%0d) last %b want (%0d,%0d)", ifb.oRow, ifb.oCol, ifb.oLast, er, ec); end
        if (ec == 4) begin ec = 0; er++; end else ec++;
      end
      if (!got_done) @(negedge clk);
    end
    n_cmp++; if (!got_done || nwin != 20) begin n_bad++; $display("FAIL b_count: got %0d windows done %0d want 20 done 1", nwin, got_done); end
    n_cmp++; if (csb - cs0 != 50) begin n_bad++; $display("FAIL b_inframe_reads: got %0d want 50", csb - cs0); end
  endtask

  task automatic test_backpressure();
    ifa.iStart = 1; @(negedge clk); ifa.iStart = 0;
    repeat (10) @(negedge clk);
    ifa.iBusy = 1;
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if ({ifa.oValid, ifa.oCs} !== 2'b10 || ifa.oOut4 !== 24'd7 || ifa.oOut0 !== 24'd1 || {ifa.oRow, ifa.oCol} !== 32'd0) begin n_bad++;
        $display("FAIL bp_hold%0d: valid %b cs %b out4 %0d (%0d,%0d) want 1 0 7 (0,0)", i, ifa.oValid, ifa.oCs, ifa.oOut4, ifa.oRow, ifa.oCol); end
      @(negedge clk);
    end
    ifa.iBusy = 0;
    n_cmp++; if (ifa.oValid !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", ifa.oValid); end
    @(negedge clk);
    n_cmp++; if (ifa.oValid !== 1'b0) begin n_bad++; $display("FAIL bp_r1: got %b want 0", ifa.oValid); end
    repeat (3) @(negedge clk);
    n_cmp++; if (ifa.oValid !== 1'b0) begin n_bad++; $display("FAIL bp_r4: got %b want 0", ifa.oValid); end
    @(negedge clk);
    ifa.iBusy = 1;
    n_cmp++; if (ifa.oValid !== 1'b1 || ifa.oCol !== 16'd1 || ifa.oOut4 !== 24'd8) begin n_bad++;
      $display("FAIL bp_r5: valid %b col %0d out4 %0d want 1 1 8", ifa.oValid, ifa.oCol, ifa.oOut4); end
  endtask

  task automatic test_stride2();
    int s, nwin;
    bit got_done;
    ifc.iStart = 1; s = cyc; @(negedge clk); ifc.iStart = 0;
    repeat (10) @(negedge clk);
    n_cmp++; if (ifc.oValid !== 1'b1 || ifc.oOut0 !== 24'd1 || ifc.oOut4 !== 24'd7) begin n_bad++;
      $display("FAIL c_first: valid %b out0 %0d out4 %0d want 1 1 7", ifc.oValid, ifc.oOut0, ifc.oOut4); end
    repeat (7) @(negedge clk);
    n_cmp++; if (ifc.oValid !== 1'b0) begin n_bad++; $display("FAIL c_gap7: got %b want 0", ifc.oValid); end
    @(negedge clk);
    n_cmp++; if (ifc.oValid !== 1'b1 || ifc.oCol !== 16'd1 || ifc.oOut0 !== 24'd3 || ifc.oOut4 !== 24'd9) begin n_bad++;
      $display("FAIL c_win01: valid %b col %0d out0 %0d out4 %0d want 1 1 3 9", ifc.oValid, ifc.oCol, ifc.oOut0, ifc.oOut4); end
    nwin = 2; got_done = 0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      @(negedge clk);
      if (ifc.oDone) got_done = 1;
      else if (ifc.oValid) begin
        nwin++;
        if (nwin == 3) begin
          n_cmp++; if (cyc - s != 30 || {ifc.oRow, ifc.oCol} !== {16'd1, 16'd0} || ifc.oOut0 !== 24'd11) begin n_bad++;
            $display("FAIL c_win10: cycle %0d (%0d,%0d) out0 %0d want 30 (1,0) 11", cyc - s, ifc.oRow, ifc.oCol, ifc.oOut0); end
        end
        if (nwin == 4) begin
          n_cmp++; if (ifc.oLast !== 1'b1 || ifc.oOut8 !== 24'd25) begin n_bad++;
            $display("FAIL c_win11: last %b out8 %0d want 1 25", ifc.oLast, ifc.oOut8); end
        end
      end
    end
    n_cmp++; if (!got_done || nwin != 4) begin n_bad++; $display("FAIL c_count: got %0d windows done %0d want 4 done 1", nwin, got_done); end
  endtask

  task automatic test_restart();
    int s, nwin;
    bit got_done;
    ifa.iStart = 1; @(negedge clk); ifa.iStart = 0;
    n_cmp++; if (ifa.oValid !== 1'b1 || ifa.oCol !== 16'd1) begin n_bad++;
      $display("FAIL rs_emit_start: valid %b col %0d want 1 1", ifa.oValid, ifa.oCol); end
    ifa.iBusy = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ifa.oCs !== 1'b1) begin n_bad++; $display("FAIL rs_midfetch: got cs %b want 1", ifa.oCs); end
    rst = 1'b1; @(negedge clk);
    n_cmp++; if ({ifa.oCs, ifa.oValid, ifa.oDone} !== 3'b0 || ifa.oAddr !== 17'd0 || ifa.oCol !== 16'd0 || ifa.oOut0 !== 24'd0) begin n_bad++;
      $display("FAIL rs_reset: cs %b valid %b addr %0d col %0d out0 %0d want all 0", ifa.oCs, ifa.oValid, ifa.oAddr, ifa.oCol, ifa.oOut0); end
    rst = 1'b0; @(negedge clk);
    ifa.iStart = 1; s = cyc; @(negedge clk); ifa.iStart = 0;
    repeat (4) @(negedge clk);
    ifa.iStart = 1; @(negedge clk); ifa.iStart = 0;
    repeat (4) @(negedge clk);
    n_cmp++; if (ifa.oValid !== 1'b0 || cyc - s != 10) begin n_bad++; $display("FAIL rs_c10: valid %b at %0d want 0 at 10", ifa.oValid, cyc - s); end
    @(negedge clk);
    n_cmp++; if (ifa.oValid !== 1'b1 || {ifa.oRow, ifa.oCol} !== 32'd0 || ifa.oOut0 !== 24'd1) begin n_bad++;
      $display("FAIL rs_c11: valid %b (%0d,%0d) out0 %0d want 1 (0,0) 1", ifa.oValid, ifa.oRow, ifa.oCol, ifa.oOut0); end
    nwin = 1; got_done = 0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      @(negedge clk);
      if (ifa.oDone) got_done = 1;
      else if (ifa.oValid) nwin++;
    end
    n_cmp++; if (!got_done || nwin != 6) begin n_bad++; $display("FAIL rs_count: got %0d windows done %0d want 6 done 1", nwin, got_done); end
  endtask

  initial begin
    test_reset();
    test_valid_only();
    test_padding();
    test_backpressure();
    test_stride2();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/window_gen_kxk.md
# window_gen_kxk

Parametrised 3x3 window generator for the CNN front end. On a start pulse it walks a WIDTH x HEIGHT frame stored in the input BRAM and emits one 3x3 neighbourhood per output position to the MAC stage. It generalises the fixed 3x3 window unit with a configurable frame size, optional zero padding ("same" output size), stride 1 or 2, frame start/done control and output coordinates. All window traffic is back-pressured by the MAC busy signal.

## Interface
- DATA_W, 24: pixel width (RGB888); padding value is all-zero.
- ADDR_W, 17: BRAM address width; WIDTH*HEIGHT <= 2^ADDR_W.
- WIDTH, 480: frame width in pixels, >= 3.
- HEIGHT, 272: frame height in pixels, >= 3.
- PAD, 1: 0 = valid-only windows; 1 = one-pixel zero border.
- STRIDE, 1: 1 or 2, applied to both rows and columns.

- iClk  in  1  clock; all logic on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iStart  in  1  one-cycle frame start; ignored unless IDLE.
- oCs  out  1  BRAM read enable.
- oAddr  out  ADDR_W  BRAM read address, row*WIDTH+col; 0 when oCs=0.
- iPixel  in  DATA_W  BRAM read data, valid the cycle after oCs.
- oOut0..oOut8  out  DATA_W each  window, row-major, oOut0 top-left, oOut4 centre.
- oValid  out  1  window valid.
- iBusy  in  1  MAC busy; transfer = oValid & !iBusy.
- oRow, oCol  out  16 each  output coordinates of the current window.
- oLast  out  1  high with oValid on the final window of the frame.
- oDone  out  1  one-cycle pulse after the final transfer.

## Operation
- Output size: PAD=0: OW=(WIDTH-3)/STRIDE+1, OH=(HEIGHT-3)/STRIDE+1. PAD=1: OW=(WIDTH-1)/STRIDE+1, OH=(HEIGHT-1)/STRIDE+1. Integer division.
- Window (r,c) covers input rows r*STRIDE-PAD+{0,1,2} and columns c*STRIDE-PAD+{0,1,2}.
- The window is held as three column registers (3 pixels each). A column fetch reads rows top to bottom, one address per cycle.
  - An out-of-bounds pixel keeps its issue slot but drives oCs=0 and inserts zero.
  - The read count therefore never depends on the border.
- When a fetched column completes, the columns shift left and the new column enters on the right.
- FSM states:
  - IDLE: iStart leads to FETCH with r=c=0.
  - FETCH: issues 9 reads at a row start, else 3*STRIDE reads.
  - DRAIN: one cycle to capture the last read.
  - EMIT: oValid=1.
    - On transfer: if c<OW-1, then c++ and go to FETCH.
    - Else if r<OH-1, then r++, c=0 and go to FETCH (row start).
    - Else go to DONE.
  - DONE: oDone=1 for one cycle, then IDLE.
- Window, oRow and oCol change only in FETCH/DRAIN, so they are stable for the whole of EMIT.
- iStart outside IDLE has no effect.

## Timing
- Reset values: all outputs 0, FSM in IDLE, r=c=0.
- iStart sampled at cycle 0 → addresses on cycles 1..9 → data captured on cycles 2..10 → oValid=1 from cycle 11.
- Transfer at cycle T, same row: stride 1 gives addresses T+1..T+3 and oValid at T+5; stride 2 gives addresses T+1..T+6 and oValid at T+8.
- Transfer at cycle T on a row's last window: addresses T+1..T+9, oValid at T+11.
- iBusy=1 during EMIT holds oValid, the window and the coordinates, with no reads issued. The transfer happens on the first cycle with iBusy=0.
- Final transfer at T → oDone=1 at T+1, oValid=0 at T+1, IDLE at T+2.
- iRst at any cycle, including mid-fetch: next cycle IDLE with all outputs 0. An in-flight BRAM datum is discarded.

## Test plan
Bench uses a BRAM model with 1-cycle latency and pixel value = address+1.
- **PAD=0, STRIDE=1, WIDTH=5, HEIGHT=4:** iStart → 6 windows; first window oOut0=1, oOut4=7, oOut8=13 at cycle 11; oLast on window (1,2); oDone one cycle after its transfer.
- **PAD=1, STRIDE=1, WIDTH=5, HEIGHT=4:** 20 windows.
  - First window: oOut0,1,2,3,6=0; oOut4=1, oOut5=2, oOut7=6, oOut8=7.
  - Window (3,4): oOut0=14, oOut1=15, oOut3=19, oOut4=20; the rest 0.
  - oCs is never high for an out-of-frame address.
- **iBusy=1 for 7 cycles while oValid:** window and coordinates unchanged, oCs=0 throughout; next oValid 5 cycles after the release cycle.
- **PAD=0, STRIDE=2, WIDTH=5, HEIGHT=5:** 4 windows; window (0,1) has oOut0=3, oOut4=9; inter-window gap of 8 cycles within a row.
- **Reset and restart:** iRst mid-frame → outputs 0 next cycle. iStart during an active frame is ignored. iStart after reset restarts at (0,0) with the first oValid at cycle 11.
